div: RTL and testbench



---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 29 ++
 rtl/div.sv | 138 +++++++++++++
 tb/tb_div.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   WIDTH         - operand / quotient / remainder width
//   CNT_W         - iteration counter width, log2(WIDTH)
//   DIV_BY_ZERO_Q - quotient reported for a zero divisor
//   state_t       - controller state encoding
package div_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_FIX  = 3'd2,
        S_ZERO = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
//   part     - partial remainder with the next dividend bit shifted in (WIDTH+1)
//   dsr      - divisor magnitude, zero-extended (WIDTH+1)
//   rem_next - partial remainder after the trial subtraction
//   q_bit    - quotient bit produced by this iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   part,
    input  logic [WIDTH:0]   dsr,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    import div_pkg::*;

    // The remainder after a successful subtraction is always below the
    // divisor, and a restored remainder is also below the divisor, so the
    // top bit of the (WIDTH+1)-bit partial remainder is always zero here.
    always_comb begin
        q_bit    = (part >= dsr);
        rem_next = part[WIDTH-1:0];
        if (q_bit) begin
            rem_next = WIDTH'(part - dsr);
        end else begin
            rem_next = part[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div.sv
// Iterative radix-2 restoring divider, signed or unsigned.
//   div_clk, reset           - clock, asynchronous active-high reset
//   div_valid/div_ready      - request handshake; div_signed, x, y sampled at accept
//   cancel                   - abort any in-flight or held operation
//   out_valid/out_ready      - result handshake
//   s, r                     - quotient, remainder (registered, stable while held)
module div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             div_clk,
    input  logic             reset,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cancel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r
);
    import div_pkg::*;

    // Magnitude of a WIDTH-bit value; as an unsigned result |-2^(WIDTH-1)|
    // is representable without an extra bit.
    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v, input logic neg);
        mag_f = neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] dvd_r;     // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] rem_r;     // partial remainder
    logic [WIDTH-1:0] dsr_r;     // divisor magnitude
    logic             q_neg_r;
    logic             r_neg_r;

    logic [WIDTH:0]   part_s;
    logic [WIDTH-1:0] rem_next_s;
    logic             q_bit_s;

    // Next partial remainder takes the top not-yet-consumed dividend bit.
    always_comb begin
        part_s = {rem_r, dvd_r[WIDTH-1]};
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .part     (part_s),
        .dsr      ({1'b0, dsr_r}),
        .rem_next (rem_next_s),
        .q_bit    (q_bit_s)
    );

    // Controller and datapath registers.
    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            dvd_r     <= {WIDTH{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            dsr_r     <= {WIDTH{1'b0}};
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            div_ready <= 1'b1;
            out_valid <= 1'b0;
            s         <= {WIDTH{1'b0}};
            r         <= {WIDTH{1'b0}};
        end else if (cancel) begin
            // Cancel wins over both an accept and a result handshake.
            state_r   <= S_IDLE;
            div_ready <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (div_valid) begin
                        q_neg_r   <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
                        r_neg_r   <= div_signed & x[WIDTH-1];
                        dsr_r     <= mag_f(y, div_signed & y[WIDTH-1]);
                        rem_r     <= {WIDTH{1'b0}};
                        cnt_r     <= CNT_W'(WIDTH - 1);
                        div_ready <= 1'b0;
                        if (y != {WIDTH{1'b0}}) begin
                            dvd_r   <= mag_f(x, div_signed & x[WIDTH-1]);
                            state_r <= S_CALC;
                        end else begin
                            // Raw dividend is kept: it is reported as the remainder.
                            dvd_r   <= x;
                            state_r <= S_ZERO;
                        end
                    end else begin
                        div_ready <= 1'b1;
                    end
                end
                S_CALC: begin
                    rem_r <= rem_next_s;
                    dvd_r <= {dvd_r[WIDTH-2:0], q_bit_s};
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= S_FIX;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_FIX: begin
                    s       <= q_neg_r ? (~dvd_r + {{(WIDTH-1){1'b0}}, 1'b1}) : dvd_r;
                    r       <= r_neg_r ? (~rem_r + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_r;
                    state_r <= S_DONE;
                end
                S_ZERO: begin
                    s       <= WIDTH'(DIV_BY_ZERO_Q);
                    r       <= dvd_r;
                    state_r <= S_DONE;
                end
                S_DONE: begin
                    // out_valid rises one cycle after entering DONE; the
                    // handshake only counts once it is visible.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        div_ready <= 1'b1;
                        state_r   <= S_IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    div_ready <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed + random bench for the divider with a result scoreboard.
module tb_div;

    logic        div_clk;
    logic        reset;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic        cancel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic [31:0] r;

    typedef struct {
        logic [31:0] s;
        logic [31:0] r;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   acc_cyc = 0;

    div dut (
        .div_clk    (div_clk),
        .reset      (reset),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .x          (x),
        .y          (y),
        .cancel     (cancel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .s          (s),
        .r          (r)
    );

    initial div_clk = 1'b0;
    always #5 div_clk = ~div_clk;

    always @(posedge div_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // Reference model: native 64-bit division (truncates toward zero,
    // remainder has the dividend's sign).
    function automatic exp_t model(input logic [31:0] xv, input logic [31:0] yv, input logic sg);
        exp_t   e;
        longint xs, ys, q, m;
        if (yv == 32'd0) begin
            e.s = 32'hFFFF_FFFF;
            e.r = xv;
        end else if (sg) begin
            xs  = longint'($signed(xv));
            ys  = longint'($signed(yv));
            q   = xs / ys;
            m   = xs % ys;
            e.s = q[31:0];
            e.r = m[31:0];
        end else begin
            e.s = xv / yv;
            e.r = xv % yv;
        end
        return e;
    endfunction

    // Drive a request and wait for its accept edge; called #1 after an edge.
    task automatic send(input logic [31:0] xv, input logic [31:0] yv, input logic sg, input bit push);
        int n = 0;
        div_valid  = 1'b1;
        x          = xv;
        y          = yv;
        div_signed = sg;
        while (!div_ready && n < 100) begin
            @(posedge div_clk); #1;
            n++;
        end
        if (!div_ready) timeout("accept");
        @(posedge div_clk); #1;
        acc_cyc    = cyc;
        div_valid  = 1'b0;
        x          = $urandom;
        y          = $urandom;
        div_signed = 1'($urandom_range(0, 1));
        if (push) sb_q.push_back(model(xv, yv, sg));
    endtask

    task automatic wait_valid(output int lat);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(posedge div_clk); #1;
            n++;
        end
        if (out_valid) lat = cyc - acc_cyc;
        else begin
            lat = -1;
            timeout("out_valid");
        end
    endtask

    // Wait for a result with out_ready held high, check it and the handshake.
    task automatic get_result(input string tag, input int exp_lat);
        int   lat;
        exp_t e;
        wait_valid(lat);
        if (lat >= 0) begin
            e = sb_q.pop_front();
            chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
            chk({tag, "_s"}, s, e.s);
            chk({tag, "_r"}, r, e.r);
            @(posedge div_clk); #1;
            chk({tag, "_ov_clr"}, {31'd0, out_valid}, 32'd0);
            chk({tag, "_rdy"}, {31'd0, div_ready}, 32'd1);
        end
    endtask

    task automatic no_result(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge div_clk); #1;
            if (out_valid) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int   lat;
        exp_t e;
        logic [31:0] rx, ry;
        int   mode;
        logic sg;

        reset = 1'b1; div_valid = 1'b0; div_signed = 1'b0;
        x = 32'd0; y = 32'd0; cancel = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge div_clk);
        #1;
        chk("rst_ready", {31'd0, div_ready}, 32'd1);
        chk("rst_ovalid", {31'd0, out_valid}, 32'd0);
        chk("rst_s", s, 32'd0);
        chk("rst_r", r, 32'd0);
        reset = 1'b0;
        @(posedge div_clk); #1;

        // Basic unsigned and signed cases
        send(32'd100, 32'd7, 1'b0, 1'b1);              get_result("u100_7", 34);
        send(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);        get_result("sm7_2", 34);
        send(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);        get_result("s7_m2", 34);
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1); get_result("ovf", 34);
        send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);        get_result("umax_1", 34);
        send(32'd5, 32'd9, 1'b0, 1'b1);                get_result("small", 34);
        send(32'd0, 32'hFFFF_FFFD, 1'b1, 1'b1);        get_result("zero_dvd", 34);

        // Divide by zero
        send(32'h1234_5678, 32'd0, 1'b0, 1'b1);        get_result("dz_u", 2);
        send(32'h1234_5678, 32'd0, 1'b1, 1'b1);        get_result("dz_s", 2);

        // Backpressure, with a competing request during the release cycle
        out_ready = 1'b0;
        send(32'd1000, 32'd7, 1'b0, 1'b1);
        wait_valid(lat);
        if (lat >= 0) begin
            e = sb_q.pop_front();
            chk("bp_lat", 32'(lat), 32'd34);
            chk("bp_s", s, e.s);
            chk("bp_r", r, e.r);
            div_valid = 1'b1; x = 32'd5; y = 32'd1; div_signed = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge div_clk); #1;
                chk("bp_hold_ov", {31'd0, out_valid}, 32'd1);
                chk("bp_hold_s", s, e.s);
                chk("bp_hold_r", r, e.r);
                chk("bp_hold_rdy", {31'd0, div_ready}, 32'd0);
            end
            out_ready = 1'b1;
            @(posedge div_clk); #1;
            div_valid = 1'b0;
            chk("bp_rel_ov", {31'd0, out_valid}, 32'd0);
            chk("bp_rel_rdy", {31'd0, div_ready}, 32'd1);
        end
        no_result("bp_no_extra", 40);

        // Cancel while the counter reads 15
        send(32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (16) @(posedge div_clk);
        #1; cancel = 1'b1;
        @(posedge div_clk); #1; cancel = 1'b0;
        chk("cxl_rdy", {31'd0, div_ready}, 32'd1);
        no_result("cxl_none", 40);
        send(32'd50, 32'd5, 1'b0, 1'b1);               get_result("after_cxl", 34);

        // Cancel coincident with accept
        div_valid = 1'b1; x = 32'd77; y = 32'd7; div_signed = 1'b0; cancel = 1'b1;
        @(posedge div_clk); #1;
        div_valid = 1'b0; cancel = 1'b0;
        chk("cxl_acc_rdy", {31'd0, div_ready}, 32'd1);
        no_result("cxl_acc_none", 40);

        // Async reset between edges, mid-computation
        send(32'd123456, 32'd7, 1'b0, 1'b0);
        repeat (10) @(posedge div_clk);
        #3; reset = 1'b1;
        #1;
        chk("arst_ready", {31'd0, div_ready}, 32'd1);
        chk("arst_ovalid", {31'd0, out_valid}, 32'd0);
        chk("arst_s", s, 32'd0);
        chk("arst_r", r, 32'd0);
        #2; reset = 1'b0;
        @(posedge div_clk); #1;
        no_result("arst_none", 40);

        // Random pairs
        for (int i = 0; i < 1000; i++) begin
            mode = $urandom_range(0, 9);
            sg   = 1'($urandom_range(0, 1));
            rx   = $urandom;
            ry   = $urandom;
            case (mode)
                0: rx = 32'd0;
                1: ry = 32'd0;
                2: begin rx = 32'($urandom_range(0, 1000)); ry = ry | 32'h0100_0000; ry[31] = 1'b0; end
                3: ry = 32'($urandom_range(1, 20));
                4: ry = -32'($urandom_range(1, 20));
                default: ;
            endcase
            send(rx, ry, sg, 1'b1);
            get_result("rnd", (ry == 32'd0) ? 2 : 34);
        end

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
